// File: rtl/control_unit.sv
// Main instruction decoder: maps a 4-bit opcode to ALU select, branch, operand-B
// source, register write and illegal flags, all registered with one cycle of latency.
module control_unit #(
  parameter int OPCODE_W = 4,
  parameter int ALUCTL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic                Branch,
  output logic                ALUSrc,
  output logic                RegWrite,
  output logic                Illegal
);

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  logic [ALUCTL_W-1:0] alu_ctl_d, alu_ctl_q;
  logic                branch_d, branch_q;
  logic                alu_src_d, alu_src_q;
  logic                reg_write_d, reg_write_q;
  logic                illegal_d, illegal_q;

  // Opcode decode; anything outside the defined set, including X/Z, lands on the NOP/illegal row.
  always_comb begin
    alu_ctl_d   = ALU_ADD;
    branch_d    = 1'b0;
    alu_src_d   = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b1;
    case (opcode)
      4'b0000: begin alu_ctl_d = ALU_ADD; reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0001: begin alu_ctl_d = ALU_SUB; reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0010: begin alu_ctl_d = ALU_AND; reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0011: begin alu_ctl_d = ALU_OR;  reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0100: begin alu_ctl_d = ALU_ADD; alu_src_d = 1'b1; reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0101: begin alu_ctl_d = ALU_SUB; alu_src_d = 1'b1; reg_write_d = 1'b1; illegal_d = 1'b0; end
      4'b0110: begin alu_ctl_d = ALU_SUB; branch_d = 1'b1; illegal_d = 1'b0; end
      4'b0111: begin alu_ctl_d = ALU_ADD; illegal_d = 1'b0; end
      default: begin
        alu_ctl_d   = ALU_ADD;
        branch_d    = 1'b0;
        alu_src_d   = 1'b0;
        reg_write_d = 1'b0;
        illegal_d   = 1'b1;
      end
    endcase
  end

  // Output registers; reset takes priority over the decode on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctl_q   <= ALU_ADD;
      branch_q    <= 1'b0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      alu_ctl_q   <= alu_ctl_d;
      branch_q    <= branch_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ALUControl = alu_ctl_q;
  assign Branch     = branch_q;
  assign ALUSrc     = alu_src_q;
  assign RegWrite   = reg_write_q;
  assign Illegal    = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed scenarios plus randomized opcode/reset
// traffic compared against a rule-based reference model delayed by one cycle.
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] opcode;
  logic [1:0] ALUControl;
  logic       Branch;
  logic       ALUSrc;
  logic       RegWrite;
  logic       Illegal;

  int n_total;
  int n_bad;

  control_unit #(.OPCODE_W(4), .ALUCTL_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .ALUControl (ALUControl),
    .Branch     (Branch),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .Illegal    (Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of the outputs: {ALUControl, Branch, ALUSrc, RegWrite, Illegal}
  function automatic logic [5:0] outs();
    return {ALUControl, Branch, ALUSrc, RegWrite, Illegal};
  endfunction

  // Reference decode built from instruction semantics rather than a table copy
  function automatic logic [5:0] ref_decode(input int op, input logic rst);
    logic [1:0] alu;
    logic br, src, rw, ill;
    if (rst) return 6'b000000;
    if (op > 7) return 6'b000001;
    br  = (op == 6);
    src = (op == 4) || (op == 5);
    rw  = (op <= 5);
    ill = 1'b0;
    if (op <= 5) alu = 2'(op % 4);
    else if (op == 6) alu = 2'd1;
    else alu = 2'd0;
    return {alu, br, src, rw, ill};
  endfunction

  task automatic check_val(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Apply inputs on the falling edge, then check one step after the next rising edge
  task automatic step(input logic r, input logic [3:0] op, input string tag);
    @(negedge clk);
    reset  = r;
    opcode = op;
    @(posedge clk);
    #1;
    check_val(tag, outs(), ref_decode(int'(op), r));
    check_val({tag, "_excl"}, {5'b0, Branch & RegWrite}, 6'b000000);
  endtask

  initial begin
    logic [3:0] ill_ops [3];
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    opcode  = 4'b0000;

    step(1'b1, 4'b0000, "reset0");
    step(1'b1, 4'b0000, "reset1");
    check_val("reset_lit", outs(), 6'b000000);
    step(1'b0, 4'b0000, "release");
    check_val("release_lit", outs(), 6'b000010);

    for (int op = 0; op < 8; op++) begin
      step(1'b0, 4'(op), "sweep_a");
      step(1'b0, 4'(op), "sweep_b");
    end
    step(1'b0, 4'b0100, "addi");
    check_val("addi_lit", outs(), 6'b000110);
    step(1'b0, 4'b0110, "beq");
    check_val("beq_lit", outs(), 6'b011000);

    ill_ops[0] = 4'b1000;
    ill_ops[1] = 4'b1010;
    ill_ops[2] = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, ill_ops[i], "illegal");
      check_val("illegal_lit", outs(), 6'b000001);
    end
    step(1'b0, 4'b0011, "or_after_ill");
    check_val("or_lit", outs(), 6'b110010);

    step(1'b0, 4'b0001, "lat_sub");
    @(negedge clk);
    opcode = 4'b0110;
    #1;
    check_val("lat_hold", outs(), 6'b010010);
    @(posedge clk);
    #1;
    check_val("lat_beq", outs(), 6'b011000);

    step(1'b0, 4'b0010, "mid_and");
    step(1'b1, 4'b0010, "mid_reset");
    check_val("mid_reset_lit", outs(), 6'b000000);
    step(1'b0, 4'b0010, "mid_release");
    check_val("mid_release_lit", outs(), 6'b100010);

    for (int c = 0; c < 1000; c++) begin
      step(($urandom_range(0, 9) == 0), 4'($urandom_range(0, 15)), "rand");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
